// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS coprocessor-0 register file (BadVAddr, Count, Compare,
// Status, Cause, EPC) serving mfc0/mtc0, exception commit and eret.
// Optional Count/Compare timer interrupt enabled by macro CP0_TIMER_INT_EN.
module cp0_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic [5:0]  hw_int,
    input  logic        exception_occur,
    input  logic        Write_EPC,
    input  logic [31:0] EPC_in,
    input  logic        new_Cause_BD1,
    input  logic        WriteExcCode,
    input  logic [4:0]  ExcCode_in,
    input  logic        write_BadVAddr,
    input  logic [31:0] BadVAddr_in,
    input  logic        eret,
    output logic [31:0] Status,
    output logic [31:0] Cause,
    output logic [31:0] EPC,
    output logic [7:0]  Cause_IP,
    output logic [7:0]  Status_IM,
    output logic        timer_int
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q,    count_d;
    logic [31:0] compare_q,  compare_d;
    logic        tick_q,     tick_d;
    logic [7:0]  im_q,       im_d;
    logic        exl_q,      exl_d;
    logic        ie_q,       ie_d;
    logic        bd_q,       bd_d;
    logic        ti_q,       ti_d;
    logic [7:0]  ip_q,       ip_d;
    logic [4:0]  exccode_q,  exccode_d;
    logic [31:0] epc_q,      epc_d;

    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [31:0] count_inc;

    assign wr_count   = we && (waddr == ADDR_COUNT);
    assign wr_compare = we && (waddr == ADDR_COMPARE);
    assign wr_status  = we && (waddr == ADDR_STATUS);
    assign wr_cause   = we && (waddr == ADDR_CAUSE);
    assign wr_epc     = we && (waddr == ADDR_EPC);
    assign count_inc  = count_q + 32'd1;

    // Next-state for every field; priority exception > eret > mtc0 per field
    always_comb begin
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        tick_d     = ~tick_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = 1'b0;
        ip_d       = ip_q;
        exccode_d  = exccode_q;
        epc_d      = epc_q;

        // Count: loads on mtc0 (restarting the half-rate phase), else ticks
        if (wr_count) begin
            count_d = wdata;
            tick_d  = 1'b0;
        end else if (tick_q) begin
            count_d = count_inc;
        end

        if (wr_compare) begin
            compare_d = wdata;
        end

`ifdef CP0_TIMER_INT_EN
        // Compare write clear beats a simultaneous match
        if (wr_compare) begin
            ti_d = 1'b0;
        end else if (tick_q && !wr_count && (count_inc == compare_q)) begin
            ti_d = 1'b1;
        end else begin
            ti_d = ti_q;
        end
`endif

        // Status: mtc0 writes IM/EXL/IE; eret then exception override EXL only
        if (wr_status) begin
            im_d  = wdata[15:8];
            exl_d = wdata[1];
            ie_d  = wdata[0];
        end
        if (eret) begin
            exl_d = 1'b0;
        end
        if (exception_occur) begin
            exl_d = 1'b1;
        end

        // Cause: hardware lines sampled every cycle, software IP via mtc0
        ip_d[7]   = hw_int[5] | ti_q;
        ip_d[6:2] = hw_int[4:0];
        if (wr_cause) begin
            ip_d[1:0] = wdata[9:8];
        end
        if (exception_occur) begin
            bd_d = new_Cause_BD1;
            if (WriteExcCode) begin
                exccode_d = ExcCode_in;
            end
        end

        // EPC: mtc0 accepted unless the exception loads it this cycle
        if (exception_occur && Write_EPC) begin
            epc_d = EPC_in;
        end else if (wr_epc) begin
            epc_d = wdata;
        end

        if (exception_occur && write_BadVAddr) begin
            badvaddr_d = BadVAddr_in;
        end
    end

    // State registers with synchronous reset overriding every strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            tick_q     <= 1'b0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_q       <= '0;
            exccode_q  <= '0;
            epc_q      <= '0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            tick_q     <= tick_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_q       <= ip_d;
            exccode_q  <= exccode_d;
            epc_q      <= epc_d;
        end
    end

    assign Status    = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign Cause     = {bd_q, ti_q, 14'b0, ip_q, 1'b0, exccode_q, 2'b0};
    assign EPC       = epc_q;
    assign Cause_IP  = ip_q;
    assign Status_IM = im_q;
    assign timer_int = ti_q;

    // mfc0 read mux from current register state
    always_comb begin
        rdata = '0;
        case (raddr)
            ADDR_BADVADDR: rdata = badvaddr_q;
            ADDR_COUNT:    rdata = count_q;
            ADDR_COMPARE:  rdata = compare_q;
            ADDR_STATUS:   rdata = Status;
            ADDR_CAUSE:    rdata = Cause;
            ADDR_EPC:      rdata = epc_q;
            default:       rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed and randomized checks of cp0_regfile against a
// field-level reference model. Honours CP0_TIMER_INT_EN like the design.
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst, we, exception_occur, Write_EPC, new_Cause_BD1;
    logic        WriteExcCode, write_BadVAddr, eret;
    logic [4:0]  waddr, raddr, ExcCode_in;
    logic [31:0] wdata, EPC_in, BadVAddr_in;
    logic [5:0]  hw_int;
    logic [31:0] rdata, Status, Cause, EPC;
    logic [7:0]  Cause_IP, Status_IM;
    logic        timer_int;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    cp0_regfile dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .hw_int(hw_int),
        .exception_occur(exception_occur), .Write_EPC(Write_EPC),
        .EPC_in(EPC_in), .new_Cause_BD1(new_Cause_BD1),
        .WriteExcCode(WriteExcCode), .ExcCode_in(ExcCode_in),
        .write_BadVAddr(write_BadVAddr), .BadVAddr_in(BadVAddr_in),
        .eret(eret), .Status(Status), .Cause(Cause), .EPC(EPC),
        .Cause_IP(Cause_IP), .Status_IM(Status_IM), .timer_int(timer_int)
    );

    always #5 clk = ~clk;

    // Reference model: architectural fields; Count kept as a base value plus
    // the number of clock edges since it was loaded (it advances every 2nd).
    logic [31:0] m_bad, m_cmp, m_epc, m_cbase;
    int unsigned m_cn;
    logic [7:0]  m_im, m_ip;
    logic        m_exl, m_ie, m_bd, m_ti;
    logic [4:0]  m_exc;

    function automatic logic [31:0] m_count();
        return m_cbase + 32'(m_cn / 2);
    endfunction

    function automatic logic [31:0] m_status();
        return 32'h0040_0000 | {16'b0, m_im, 6'b0, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, m_ti, 14'b0, m_ip, 1'b0, m_exc, 2'b0};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count();
            5'd11:   return m_cmp;
            5'd12:   return m_status();
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic clear_strobes();
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        exception_occur = 1'b0; Write_EPC = 1'b0; EPC_in = '0;
        new_Cause_BD1 = 1'b0; WriteExcCode = 1'b0; ExcCode_in = '0;
        write_BadVAddr = 1'b0; BadVAddr_in = '0; eret = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
    endtask

    // Apply current inputs for one clock, advance the model, check outputs
    task automatic cycle();
        logic [31:0] cur_cnt, new_cnt;
        logic        cw, old_ti;
        if (rst) begin
            m_bad = '0; m_cmp = '0; m_epc = '0; m_cbase = '0; m_cn = 0;
            m_im = '0; m_ip = '0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0;
            m_ti = 1'b0; m_exc = '0;
        end else begin
            old_ti  = m_ti;
            cur_cnt = m_count();
            cw      = we && (waddr == 5'd9);
            if (cw) begin
                m_cbase = wdata; m_cn = 0;
            end else begin
                m_cn++;
            end
            new_cnt = m_count();
`ifdef CP0_TIMER_INT_EN
            if (we && waddr == 5'd11) m_ti = 1'b0;
            else if (!cw && new_cnt != cur_cnt && new_cnt == m_cmp) m_ti = 1'b1;
`endif
            if (we && waddr == 5'd11) m_cmp = wdata;
            m_ip[7:2] = {hw_int[5] | old_ti, hw_int[4:0]};
            if (we && waddr == 5'd13) m_ip[1:0] = wdata[9:8];
            if (we && waddr == 5'd12) begin
                m_im = wdata[15:8]; m_exl = wdata[1]; m_ie = wdata[0];
            end
            if (eret) m_exl = 1'b0;
            if (we && waddr == 5'd14) m_epc = wdata;
            if (exception_occur) begin
                m_exl = 1'b1;
                m_bd  = new_Cause_BD1;
                if (WriteExcCode)   m_exc = ExcCode_in;
                if (Write_EPC)      m_epc = EPC_in;
                if (write_BadVAddr) m_bad = BadVAddr_in;
            end
        end
        @(posedge clk);
        #1;
        check("Status", Status, m_status());
        check("Cause", Cause, m_cause());
        check("EPC", EPC, m_epc);
        check("Cause_IP", {24'b0, Cause_IP}, {24'b0, m_ip});
        check("Status_IM", {24'b0, Status_IM}, {24'b0, m_im});
        check("timer_int", {31'b0, timer_int}, {31'b0, m_ti});
        check("rdata", rdata, m_read(raddr));
    endtask

    task automatic peek(input logic [4:0] a, input string tag, input logic [31:0] exp);
        raddr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    function automatic logic [4:0] pick_addr();
        case ($urandom_range(0, 6))
            0:       return 5'd8;
            1:       return 5'd9;
            2:       return 5'd11;
            3:       return 5'd12;
            4:       return 5'd13;
            5:       return 5'd14;
            default: return 5'($urandom);
        endcase
    endfunction

    initial begin
        logic found;
        logic exp_ti;
`ifdef CP0_TIMER_INT_EN
        exp_ti = 1'b1;
`else
        exp_ti = 1'b0;
`endif
        clear_strobes();
        hw_int = '0; raddr = 5'd12;
        m_cn = 0; m_cbase = '0; m_ti = 1'b0;

        // Reset values
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        peek(5'd12, "reset Status", 32'h0040_0000);
        peek(5'd13, "reset Cause", 32'h0);
        peek(5'd14, "reset EPC", 32'h0);
        peek(5'd8,  "reset BadVAddr", 32'h0);

        // Exception commit
        exception_occur = 1'b1; Write_EPC = 1'b1; WriteExcCode = 1'b1;
        write_BadVAddr = 1'b1; EPC_in = 32'hBFC0_0100; ExcCode_in = 5'h04;
        BadVAddr_in = 32'h1234_5673; new_Cause_BD1 = 1'b1;
        cycle();
        clear_strobes();
        check("exc EPC", EPC, 32'hBFC0_0100);
        check("exc Cause", Cause, 32'h8000_0010);
        check("exc EXL", {31'b0, Status[1]}, 32'h1);
        peek(5'd8, "exc BadVAddr", 32'h1234_5673);

        // eret clears EXL
        eret = 1'b1;
        cycle();
        clear_strobes();
        check("eret EXL", {31'b0, Status[1]}, 32'h0);

        // Exception beats mtc0 on EXL, IM still written
        mtc0(5'd12, 32'h0000_FF01);
        exception_occur = 1'b1;
        cycle();
        clear_strobes();
        check("prio EXL", {31'b0, Status[1]}, 32'h1);
        check("prio IM", {24'b0, Status_IM}, 32'hFF);

        // eret beats mtc0 on EXL
        mtc0(5'd12, 32'h0000_0003);
        eret = 1'b1;
        cycle();
        clear_strobes();
        check("eret prio EXL", {31'b0, Status[1]}, 32'h0);

        // Interrupt sampling and software IP
        hw_int = 6'b000101;
        cycle();
        check("hw IP", {24'b0, Cause_IP}, 32'h14);
        mtc0(5'd13, 32'h0000_0300);
        cycle();
        clear_strobes();
        check("sw IP", {24'b0, Cause_IP}, 32'h17);
        check("ExcCode kept", {27'b0, Cause[6:2]}, 32'h4);

        // Timer: Count wraps through 0 to match Compare=1
        hw_int = '0;
        mtc0(5'd9, 32'hFFFF_FFFE);
        cycle();
        mtc0(5'd11, 32'h0000_0001);
        cycle();
        clear_strobes();
        raddr = 5'd9;
        found = 1'b0;
        for (int unsigned i = 0; i < 12 && !found; i++) begin
            cycle();
            if (rdata == 32'h1) begin
                found = 1'b1;
                check("timer at match", {31'b0, timer_int}, {31'b0, exp_ti});
            end else begin
                check("timer before match", {31'b0, timer_int}, 32'h0);
            end
        end
        check("count reached 1", {31'b0, found}, 32'h1);
        mtc0(5'd11, 32'h0000_0100);
        cycle();
        clear_strobes();
        check("timer cleared", {31'b0, timer_int}, 32'h0);

        // Randomized traffic against the model
        for (int unsigned i = 0; i < 600; i++) begin
            clear_strobes();
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 2) == 0) begin
                mtc0(pick_addr(), $urandom);
                if (waddr == 5'd9 && $urandom_range(0, 1) == 1)
                    wdata = m_cmp - 32'($urandom_range(1, 4));
            end
            raddr = pick_addr();
            if ($urandom_range(0, 3) == 0) hw_int = 6'($urandom);
            exception_occur = ($urandom_range(0, 7) == 0);
            Write_EPC = 1'($urandom); EPC_in = $urandom;
            new_Cause_BD1 = 1'($urandom);
            WriteExcCode = 1'($urandom); ExcCode_in = 5'($urandom);
            write_BadVAddr = 1'($urandom); BadVAddr_in = $urandom;
            eret = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
